// File: rtl/avr_serial_rx.sv
// UART-style receiver for the AVR serial link: 8N1 framing, LSB first,
// mid-bit sampling on a synchronized copy of rx.
`timescale 1ns/1ps
module avr_serial_rx #(
    parameter int CLK_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       new_data,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    data_q;
    logic          new_data_q;
    logic          frame_err_q;
    logic          rx_meta_q;
    logic          rx_s_q;
    logic [1:0]    sync_vld_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= WAIT_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            new_data_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            sync_vld_q  <= '0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            sync_vld_q  <= {sync_vld_q[0], 1'b1};
            new_data_q  <= 1'b0;
            frame_err_q <= 1'b0;

            unique case (state_q)
                // The synchronizer's reset-value ones say nothing about the real
                // line, so leaving WAIT_IDLE waits until both flops hold live samples.
                WAIT_IDLE: begin
                    if (sync_vld_q[1] && rx_s_q) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        if (!rx_s_q) begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                            idx_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            data_q     <= shift_q;
                            new_data_q <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            // Low stop bit: treat as a line break and wait for idle.
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= WAIT_IDLE;
            endcase
        end
    end

    assign data      = data_q;
    assign new_data  = new_data_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_avr_serial_rx.sv
// Directed bench for avr_serial_rx: frames, glitches, breaks, reset and baud skew.
`timescale 1ns/1ps
module tb_avr_serial_rx;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       new_data;
    logic       frame_err;
    logic       busy;

    int          total;
    int          bad;
    int unsigned cyc;
    int unsigned fall_cyc;
    int unsigned last_nd_cyc;
    int          nd_cnt;
    int          fe_cnt;
    int          overlap_cnt;
    int          repeat_cnt;
    logic        prev_strobe;
    logic [7:0]  rx_log[$];

    avr_serial_rx #(.CLK_PER_BIT(100)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .data     (data),
        .new_data (new_data),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (new_data) begin
            nd_cnt++;
            last_nd_cyc = cyc;
            rx_log.push_back(data);
        end
        if (frame_err) fe_cnt++;
        if (new_data && frame_err) overlap_cnt++;
        if ((new_data || frame_err) && prev_strobe) repeat_cnt++;
        prev_strobe = new_data || frame_err;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int per);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            if (i == 0) fall_cyc = cyc;
            step(per);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        step(3);
        total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h expected 00", data); end
        total++; if (new_data !== 1'b0) begin bad++; $display("FAIL reset_new_data: got %b expected 0", new_data); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b expected 1", busy); end
        rst_n = 1'b1;
        step(6);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        int nd0, fe0, lat;
        nd0 = nd_cnt;
        fe0 = fe_cnt;
        send_byte(8'hA5, 100);
        step(20);
        lat = int'(last_nd_cyc - fall_cyc);
        total++; if (nd_cnt - nd0 !== 1) begin bad++; $display("FAIL single_count: got %0d expected 1", nd_cnt - nd0); end
        total++; if (data !== 8'hA5) begin bad++; $display("FAIL single_data: got %h expected a5", data); end
        total++; if (lat < 951 || lat > 953) begin bad++; $display("FAIL single_latency: got %0d expected 952+/-1", lat); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy: got %b expected 0", busy); end
        total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL single_ferr: got %0d expected 0", fe_cnt - fe0); end
    endtask

    task automatic test_glitch();
        int nd0, fe0, n;
        logic seen;
        nd0  = nd_cnt;
        fe0  = fe_cnt;
        n    = 0;
        seen = 1'b0;
        rx   = 1'b0;
        while (n < 20) begin
            step(1);
            n++;
            if (busy) seen = 1'b1;
        end
        rx = 1'b1;
        while (busy && n < 100) begin
            step(1);
            n++;
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL glitch_busy_seen: got %b expected 1", seen); end
        total++; if (n > 55) begin bad++; $display("FAIL glitch_busy_recover: got %0d cycles expected <=55", n); end
        step(60);
        total++; if (nd_cnt - nd0 !== 0) begin bad++; $display("FAIL glitch_new_data: got %0d expected 0", nd_cnt - nd0); end
        total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL glitch_ferr: got %0d expected 0", fe_cnt - fe0); end
    endtask

    task automatic test_break();
        int nd0, fe0;
        logic [7:0] d_before;
        nd0      = nd_cnt;
        fe0      = fe_cnt;
        d_before = data;
        rx       = 1'b0;
        step(2000);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL break_busy: got %b expected 1", busy); end
        total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL break_ferr: got %0d expected 1", fe_cnt - fe0); end
        total++; if (nd_cnt - nd0 !== 0) begin bad++; $display("FAIL break_new_data: got %0d expected 0", nd_cnt - nd0); end
        total++; if (data !== d_before) begin bad++; $display("FAIL break_data: got %h expected %h", data, d_before); end
        rx = 1'b1;
        step(6);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL break_release_busy: got %b expected 0", busy); end
        nd0 = nd_cnt;
        send_byte(8'h3C, 100);
        step(20);
        total++; if (data !== 8'h3C) begin bad++; $display("FAIL break_next_data: got %h expected 3c", data); end
        total++; if (nd_cnt - nd0 !== 1) begin bad++; $display("FAIL break_next_count: got %0d expected 1", nd_cnt - nd0); end
    endtask

    task automatic test_reset_midframe();
        int nd0, fe0;
        nd0 = nd_cnt;
        fe0 = fe_cnt;
        // Frame 0x0F: start, four ones, then bit 4 low when reset hits.
        rx = 1'b0; step(100);
        rx = 1'b1; step(400);
        rx = 1'b0; step(20);
        rst_n = 1'b0;
        step(10);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy: got %b expected 1", busy); end
        rst_n = 1'b1;
        step(370);
        rx = 1'b1;
        step(200);
        total++; if (nd_cnt - nd0 !== 0) begin bad++; $display("FAIL midrst_new_data: got %0d expected 0", nd_cnt - nd0); end
        total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL midrst_ferr: got %0d expected 0", fe_cnt - fe0); end
        total++; if (data !== 8'h00) begin bad++; $display("FAIL midrst_data: got %h expected 00", data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_idle: got %b expected 0", busy); end
        send_byte(8'h81, 100);
        step(20);
        total++; if (data !== 8'h81) begin bad++; $display("FAIL midrst_next_data: got %h expected 81", data); end
        total++; if (nd_cnt - nd0 !== 1) begin bad++; $display("FAIL midrst_next_count: got %0d expected 1", nd_cnt - nd0); end
    endtask

    task automatic test_back_to_back();
        int nd0, fe0, base;
        nd0  = nd_cnt;
        fe0  = fe_cnt;
        base = rx_log.size();
        send_byte(8'h55, 100);
        send_byte(8'hFF, 100);
        step(20);
        total++; if (nd_cnt - nd0 !== 2) begin bad++; $display("FAIL b2b_count: got %0d expected 2", nd_cnt - nd0); end
        total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL b2b_ferr: got %0d expected 0", fe_cnt - fe0); end
        if (rx_log.size() >= base + 2) begin
            total++; if (rx_log[base] !== 8'h55) begin bad++; $display("FAIL b2b_first: got %h expected 55", rx_log[base]); end
            total++; if (rx_log[base+1] !== 8'hFF) begin bad++; $display("FAIL b2b_second: got %h expected ff", rx_log[base+1]); end
        end else begin
            total++; bad++;
            $display("FAIL b2b_log: got %0d entries expected %0d", rx_log.size() - base, 2);
        end
    endtask

    task automatic test_tolerance();
        int per_tab[2] = '{97, 103};
        int nd0, fe0;
        foreach (per_tab[k]) begin
            nd0 = nd_cnt;
            fe0 = fe_cnt;
            send_byte(8'h5A, per_tab[k]);
            step(30);
            total++; if (data !== 8'h5A) begin bad++; $display("FAIL tol_data_%0d: got %h expected 5a", per_tab[k], data); end
            total++; if (nd_cnt - nd0 !== 1) begin bad++; $display("FAIL tol_count_%0d: got %0d expected 1", per_tab[k], nd_cnt - nd0); end
            total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL tol_ferr_%0d: got %0d expected 0", per_tab[k], fe_cnt - fe0); end
        end
    endtask

    task automatic test_strobe_rules();
        total++; if (overlap_cnt !== 0) begin bad++; $display("FAIL strobe_overlap: got %0d expected 0", overlap_cnt); end
        total++; if (repeat_cnt !== 0) begin bad++; $display("FAIL strobe_repeat: got %0d expected 0", repeat_cnt); end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        cyc         = 0;
        fall_cyc    = 0;
        last_nd_cyc = 0;
        nd_cnt      = 0;
        fe_cnt      = 0;
        overlap_cnt = 0;
        repeat_cnt  = 0;
        prev_strobe = 1'b0;
        rst_n       = 1'b0;
        rx          = 1'b1;
        step(1);
        test_reset();
        test_single();
        test_glitch();
        test_break();
        test_reset_midframe();
        test_back_to_back();
        test_tolerance();
        test_strobe_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/avr_serial_rx.md
AVR_SERIAL_RX -- requirements
Module: avr_serial_rx

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 100: clock cycles per serial bit (50 MHz clk, 500 kbaud AVR link); legal values >= 4.
REQ-002 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port rx, input, 1: asynchronous serial line driven by the AVR (avr_tx); idle high.
REQ-005 SHALL have port data, output, 8: last correctly framed received byte.
REQ-006 SHALL have port new_data, output, 1: one-cycle strobe; data is valid and updated on this cycle.
REQ-007 SHALL have port frame_err, output, 1: one-cycle strobe; stop bit sampled low.
REQ-008 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-009 SHALL pass rx through a two-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rx_s.
REQ-010 SHALL implement states WAIT_IDLE, IDLE, START, DATA, STOP; one bit counter of width clog2(CLK_PER_BIT) and one 3-bit bit index.
REQ-011 WAIT_IDLE: stay while rx_s=0; on rx_s=1 -> IDLE.
REQ-012 IDLE: on rx_s=0 -> START with counter cleared; otherwise stay.
REQ-013 START: count to CLK_PER_BIT/2-1 (integer division); on that cycle, rx_s=0 -> DATA (counter, bit index cleared); rx_s=1 -> IDLE (glitch rejected, no strobe).
REQ-014 DATA: sample rx_s when counter reaches CLK_PER_BIT-1, then clear counter; bits shift in LSB first; after bit index 7 -> STOP.
REQ-015 STOP: sample rx_s when counter reaches CLK_PER_BIT-1; rx_s=1 -> load data from shift register, pulse new_data for exactly one cycle, -> IDLE.
REQ-016 STOP with rx_s=0 SHALL pulse frame_err for one cycle, leave data unchanged, assert no new_data, -> WAIT_IDLE (line-break handling).
REQ-017 new_data and frame_err SHALL never be high in the same cycle, and SHALL never be high for two consecutive cycles.
REQ-018 The next start bit SHALL be accepted in the cycle immediately after the STOP->IDLE transition (back-to-back frames with zero extra idle).
REQ-019 Latency: rx falling edge to new_data = 2 + CLK_PER_BIT/2 + 9*CLK_PER_BIT cycles, +/-1 for edge phase.
REQ-020 SHALL receive correctly with the transmitter bit period within +/-3% of CLK_PER_BIT.

Reset
REQ-021 With rst_n=0 at a clk edge: state=WAIT_IDLE, data=8'h00, new_data=0, frame_err=0, counters=0, synchronizer flops=1; busy then reads 1 (not IDLE).
REQ-022 Reset asserted mid-frame SHALL abort the frame with no strobe; after release, no start SHALL be detected until rx_s has been high for at least one cycle.
REQ-023 Reset SHALL have priority over every state transition and strobe.

Verification
REQ-024 CLK_PER_BIT=100, one 0xA5 frame -> exactly one new_data pulse, data=0xA5, 952+/-1 cycles after the falling edge; busy=0 afterwards.
REQ-025 20-cycle low pulse on idle line -> no new_data, no frame_err, busy back to 0 within 55 cycles.
REQ-026 rx held low for 2000 cycles (break) -> one frame_err pulse, no new_data, data unchanged, busy high until rx returns high; following 0x3C frame -> data=0x3C.
REQ-027 rst_n pulsed low during bit 4 of a frame and released while rx is low -> no strobe for that frame; next 0x81 frame -> data=0x81, single new_data.
REQ-028 Frames 0x55 then 0xFF back-to-back with no idle gap -> two new_data pulses, data 0x55 then 0xFF.
REQ-029 0x5A sent at 97 and at 103 cycles/bit -> data=0x5A each time, no frame_err.
